// File: rtl/nic_host_agent.sv
// Processor-side NIC agent: polls the NIC status registers, writes producer packets into the output buffer
// and reads arrived packets to a consumer. Optional packet counters are built when NIC_AGENT_CNT_EN is defined.
module nic_host_agent #(
  parameter int POLL_GAP = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  input  logic [63:0]      tx_pkt,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [63:0]      rx_pkt,
  input  logic             rx_ready,
  output logic [1:0]       nic_addr,
  output logic             nic_en,
  output logic             nic_wr_en,
  output logic [63:0]      nic_d_out,
  input  logic [63:0]      nic_d_in,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] rx_cnt
);

  localparam int              BO_W    = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [BO_W-1:0] BO_LOAD = BO_W'(POLL_GAP);

  typedef enum logic [2:0] {
    IDLE, TX_POLL, TX_CHK, TX_WRITE, RX_POLL, RX_CHK, RX_READ, RX_CAP
  } state_e;

  typedef enum logic {TURN_TX, TURN_RX} turn_e;

  state_e          state_q, state_d;
  turn_e           turn_q, turn_d;
  logic [BO_W-1:0] tx_bo_q, tx_bo_d;
  logic [BO_W-1:0] rx_bo_q, rx_bo_d;
  logic            rx_valid_q, rx_valid_d;
  logic [63:0]     rx_pkt_q, rx_pkt_d;
  logic            tx_elig, rx_elig;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    state_d    = state_q;
    turn_d     = turn_q;
    tx_bo_d    = (tx_bo_q != '0) ? tx_bo_q - BO_W'(1) : tx_bo_q;
    rx_bo_d    = (rx_bo_q != '0) ? rx_bo_q - BO_W'(1) : rx_bo_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    rx_pkt_d   = rx_pkt_q;
    tx_elig    = tx_valid && (tx_bo_q == '0);
    rx_elig    = !rx_valid_q && (rx_bo_q == '0);

    unique case (state_q)
      IDLE: begin
        if (tx_elig && (!rx_elig || turn_q == TURN_TX)) state_d = TX_POLL;
        else if (rx_elig)                                state_d = RX_POLL;
      end
      TX_POLL: state_d = TX_CHK;
      TX_CHK: begin
        if (nic_d_in[0]) begin
          tx_bo_d = BO_LOAD;
          turn_d  = TURN_RX;
          state_d = IDLE;
        end else begin
          state_d = TX_WRITE;
        end
      end
      TX_WRITE: begin
        turn_d  = TURN_RX;
        state_d = IDLE;
      end
      RX_POLL: state_d = RX_CHK;
      RX_CHK: begin
        if (nic_d_in[0]) begin
          state_d = RX_READ;
        end else begin
          rx_bo_d = BO_LOAD;
          turn_d  = TURN_TX;
          state_d = IDLE;
        end
      end
      RX_READ: state_d = RX_CAP;
      RX_CAP: begin
        rx_pkt_d   = nic_d_in;
        rx_valid_d = 1'b1;
        turn_d     = TURN_TX;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every flop, so all of them update from pre-edge values.
    if (!rst) begin
      state_q    <= IDLE;
      turn_q     <= TURN_TX;
      tx_bo_q    <= '0;
      rx_bo_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_pkt_q   <= '0;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      tx_bo_q    <= tx_bo_d;
      rx_bo_q    <= rx_bo_d;
      rx_valid_q <= rx_valid_d;
      rx_pkt_q   <= rx_pkt_d;
    end
  end

  // NIC strobes depend on the state register alone; reset masks them in the same cycle.
  always_comb begin
    nic_en    = 1'b0;
    nic_wr_en = 1'b0;
    nic_addr  = 2'b00;
    nic_d_out = '0;
    tx_ready  = 1'b0;
    unique case (state_q)
      TX_POLL:  begin nic_en = 1'b1; nic_addr = 2'b11; end
      TX_WRITE: begin
        nic_en    = 1'b1;
        nic_wr_en = 1'b1;
        nic_addr  = 2'b10;
        nic_d_out = tx_pkt;
        tx_ready  = 1'b1;
      end
      RX_POLL:  begin nic_en = 1'b1; nic_addr = 2'b01; end
      RX_READ:  begin nic_en = 1'b1; nic_addr = 2'b00; end
      default:  ;
    endcase
    if (!rst) begin
      nic_en    = 1'b0;
      nic_wr_en = 1'b0;
      nic_addr  = 2'b00;
      nic_d_out = '0;
      tx_ready  = 1'b0;
    end
  end

  assign rx_valid = rx_valid_q & rst;
  assign rx_pkt   = rst ? rx_pkt_q : '0;

`ifdef NIC_AGENT_CNT_EN
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;

  always_comb begin
    tx_cnt_d = tx_cnt_q + CNT_W'(state_q == TX_WRITE);
    rx_cnt_d = rx_cnt_q + CNT_W'(state_q == RX_CAP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign tx_cnt = rst ? tx_cnt_q : '0;
  assign rx_cnt = rst ? rx_cnt_q : '0;
`else
  assign tx_cnt = '0;
  assign rx_cnt = '0;
`endif

endmodule

// File: tb/tb_nic_host_agent.sv
// Self-checking bench for nic_host_agent: a timeline model of the agent plus a small NIC register model,
// compared every cycle, with directed scenarios carrying hand-computed expectations.
`timescale 1ns/1ps
module tb_nic_host_agent;
  localparam int GAP = 4;
  localparam int CW  = 16;
`ifdef NIC_AGENT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk, rst;
  logic          tx_valid, tx_ready, rx_valid, rx_ready;
  logic [63:0]   tx_pkt, rx_pkt, nic_d_out, nic_d_in;
  logic [1:0]    nic_addr;
  logic          nic_en, nic_wr_en;
  logic [CW-1:0] tx_cnt, rx_cnt;

  nic_host_agent #(.POLL_GAP(GAP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_pkt(tx_pkt), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_pkt(rx_pkt), .rx_ready(rx_ready),
    .nic_addr(nic_addr), .nic_en(nic_en), .nic_wr_en(nic_wr_en),
    .nic_d_out(nic_d_out), .nic_d_in(nic_d_in),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // NIC register model: answers reads one cycle later and logs every access.
  int          out_full_polls = 0;
  bit          in_full = 1'b0, in_autofill = 1'b0, track_alt = 1'b0;
  logic [63:0] in_buf = '0, resp = '0, last_wr_data = '0;
  int n_out_polls = 0, n_in_polls = 0, n_writes = 0, n_reads = 0, n_tx_ready = 0;
  int last_out_poll_t = 0, prev_out_poll_t = 0, last_in_poll_t = 0;
  int last_read_t = 0, last_write_t = 0, last_kind = 0, alt_viol = 0;

  always @(negedge clk) begin
    resp = '0;
    if (tx_ready) n_tx_ready++;
    if (nic_en && nic_wr_en && nic_addr == 2'b10) begin
      n_writes++;
      last_wr_data = nic_d_out;
      last_write_t = cyc;
      if (track_alt) begin
        if (last_kind == 1) alt_viol++;
        last_kind = 1;
      end
    end else if (nic_en && !nic_wr_en) begin
      case (nic_addr)
        2'b11: begin
          n_out_polls++;
          prev_out_poll_t = last_out_poll_t;
          last_out_poll_t = cyc;
          if (out_full_polls > 0) begin
            resp = 64'd1;
            out_full_polls--;
          end
        end
        2'b01: begin
          n_in_polls++;
          last_in_poll_t = cyc;
          resp = {63'd0, in_full};
        end
        2'b00: begin
          n_reads++;
          last_read_t = cyc;
          resp = in_buf;
          if (in_autofill) in_buf = in_buf + 64'd1;
          else in_full = 1'b0;
          if (track_alt) begin
            if (last_kind == 2) alt_viol++;
            last_kind = 2;
          end
        end
        default: resp = '0;
      endcase
    end
  end

  always @(posedge clk) begin
    #1 nic_d_in = resp;
  end

  // Timeline model: each transaction is a fixed sequence of cycles measured from its IDLE decision.
  bit          model_on = 1'b0;
  int          op = 0, op_t0 = 0, tx_ok_from = 0, rx_ok_from = 0;
  bit          turn_rx = 1'b0, m_rxv = 1'b0;
  logic [63:0] m_rxp = '0;
  logic [CW-1:0] m_txc = '0, m_rxc = '0;

  always @(negedge clk) begin
    logic [4:0]  e_ctl;
    logic [63:0] e_dout;
    int  k;
    bit  idle_now, rxv_t, te, re;
    if (!rst) model_on = 1'b1;
    if (model_on) begin
      e_ctl  = '0;
      e_dout = '0;
      k      = cyc - op_t0;
      if (rst) begin
        if (op == 1 && k == 1) e_ctl = 5'b0_1_0_11;
        if (op == 1 && k == 3) begin e_ctl = 5'b1_1_1_10; e_dout = tx_pkt; end
        if (op == 2 && k == 1) e_ctl = 5'b0_1_0_01;
        if (op == 2 && k == 3) e_ctl = 5'b0_1_0_00;
      end
      check("nic strobes {tx_ready,en,wr,addr}", {tx_ready, nic_en, nic_wr_en, nic_addr}, e_ctl);
      check("nic_d_out", nic_d_out, e_dout);
      check("rx_valid", rx_valid, rst ? m_rxv : 1'b0);
      check("rx_pkt", rx_pkt, rst ? m_rxp : 64'd0);
      check("counters {tx,rx}", {tx_cnt, rx_cnt}, (CNT_ON && rst) ? {m_txc, m_rxc} : '0);

      if (!rst) begin
        op = 0; tx_ok_from = cyc + 1; rx_ok_from = cyc + 1;
        turn_rx = 1'b0; m_rxv = 1'b0; m_rxp = '0; m_txc = '0; m_rxc = '0;
      end else begin
        idle_now = (op == 0);
        rxv_t    = m_rxv;
        if (rxv_t && rx_ready) m_rxv = 1'b0;
        if (op == 1 && k == 2 && nic_d_in[0]) begin
          op = 0; tx_ok_from = cyc + 1 + GAP; turn_rx = 1'b1;
        end else if (op == 1 && k == 3) begin
          op = 0; turn_rx = 1'b1; m_txc++;
        end else if (op == 2 && k == 2 && !nic_d_in[0]) begin
          op = 0; rx_ok_from = cyc + 1 + GAP; turn_rx = 1'b0;
        end else if (op == 2 && k == 4) begin
          op = 0; m_rxp = nic_d_in; m_rxv = 1'b1; m_rxc++; turn_rx = 1'b0;
        end
        if (idle_now) begin
          te = tx_valid && (cyc >= tx_ok_from);
          re = !rxv_t && (cyc >= rx_ok_from);
          if (te && re) op = turn_rx ? 2 : 1;
          else if (te)  op = 1;
          else if (re)  op = 2;
          op_t0 = cyc;
        end
      end
    end
  end

  task automatic wait_tx_ready(input int bound, input string name, output int t_seen);
    t_seen = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (tx_ready) begin t_seen = cyc; break; end
    end
    if (t_seen < 0) timeout(name);
  endtask

  task automatic wait_rx_valid(input int bound, input string name, output int t_seen);
    t_seen = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rx_valid) begin t_seen = cyc; break; end
    end
    if (t_seen < 0) timeout(name);
  endtask

  initial begin
    int n0, t, polls, w0, r0, dw;
    rst = 1'b0; tx_valid = 1'b1; tx_pkt = 64'h00FF_0000_FFFF_FFF0;
    rx_ready = 1'b0; nic_d_in = '0;

    // Reset held three cycles with a packet already offered.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset nic_en", nic_en, 1'b0);
    check("reset tx_ready", tx_ready, 1'b0);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset nic_addr", nic_addr, 2'b00);
    @(posedge clk); #1 rst = 1'b1;
    n0 = cyc;

    // TX accept: poll out-status, write, tx_ready three cycles after the decision.
    wait_tx_ready(20, "tx accept tx_ready", t);
    @(posedge clk); #1 tx_valid = 1'b0;
    check("tx accept latency", 64'(t - n0), 64'd3);
    check("tx accept poll cycle", 64'(last_out_poll_t - n0), 64'd1);
    check("tx accept write cycle", 64'(last_write_t - n0), 64'd3);
    check("tx accept write data", last_wr_data, 64'h00FF_0000_FFFF_FFF0);
    check("tx accept write count", 64'(n_writes), 64'd1);
    check("tx accept tx_cnt", tx_cnt, CNT_ON ? 64'd1 : 64'd0);

    // RX capture with the consumer stalled.
    in_buf = 64'hC0FF_0000_FFFF_AAA3; in_full = 1'b1;
    wait_rx_valid(40, "rx capture rx_valid", t);
    @(posedge clk); #1;
    check("rx capture data", rx_pkt, 64'hC0FF_0000_FFFF_AAA3);
    check("rx capture poll-to-valid", 64'(t - last_in_poll_t), 64'd4);
    check("rx capture read cycle", 64'(last_read_t - last_in_poll_t), 64'd2);
    check("rx capture read count", 64'(n_reads), 64'd1);
    polls = n_in_polls;
    repeat (20) @(posedge clk);
    #1;
    check("rx hold no re-poll", 64'(n_in_polls), 64'(polls));
    check("rx hold rx_valid", rx_valid, 1'b1);

    // TX backoff: first poll sees a full output buffer.
    out_full_polls = 1;
    tx_valid = 1'b1; tx_pkt = 64'h8012_0000_0000_1234;
    n0 = cyc;
    wait_tx_ready(40, "tx backoff tx_ready", t);
    @(posedge clk); #1 tx_valid = 1'b0;
    check("tx backoff latency", 64'(t - n0), 64'd10);
    check("tx backoff poll spacing", 64'(last_out_poll_t - prev_out_poll_t), 64'd7);
    check("tx backoff write data", last_wr_data, 64'h8012_0000_0000_1234);
    check("tx backoff write count", 64'(n_writes), 64'd2);
    repeat (6) @(posedge clk);
    #1;
    check("tx backoff single tx_ready", 64'(n_tx_ready), 64'd2);

    // Mid-operation reset while the in-buffer read is on the bus.
    in_buf = 64'h4005_0000_0000_0BAD; in_full = 1'b1;
    rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    t = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (nic_en && !nic_wr_en && nic_addr == 2'b01) begin t = cyc; break; end
    end
    if (t < 0) timeout("mid reset in-status poll");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid reset read masked", nic_en, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("mid reset rx_valid", rx_valid, 1'b0);
    check("mid reset no capture", 64'(n_reads), 64'd1);
    check("mid reset rx_cnt", rx_cnt, 64'd0);
    wait_rx_valid(40, "mid reset recapture", t);
    @(posedge clk); #1;
    check("mid reset recapture data", rx_pkt, 64'h4005_0000_0000_0BAD);

    // Fairness: producer always ready, input buffer always full, consumer always ready.
    w0 = n_writes; r0 = n_reads;
    in_autofill = 1'b1; in_full = 1'b1; in_buf = 64'h0000_0000_0000_1000;
    rx_ready = 1'b1; track_alt = 1'b1;
    tx_valid = 1'b1; tx_pkt = 64'h0001_0000_0000_5000;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        @(posedge clk); #1 tx_pkt = tx_pkt + 64'd1;
      end else begin
        @(posedge clk); #1;
      end
    end
    wait_tx_ready(20, "fairness final tx_ready", t);
    @(posedge clk); #1 tx_valid = 1'b0; in_autofill = 1'b0; in_full = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    dw = (n_writes - w0) - (n_reads - r0);
    check("fairness alternation violations", 64'(alt_viol), 64'd0);
    check("fairness tx/rx balance", 64'((dw >= -1 && dw <= 1) ? 1 : 0), 64'd1);
    check("fairness progress", 64'((n_writes - w0 >= 8) ? 1 : 0), 64'd1);
    check("fairness counter balance",
          64'((int'(tx_cnt) - int'(rx_cnt) >= -1 && int'(tx_cnt) - int'(rx_cnt) <= 1) ? 1 : 0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule
